// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the MULT/DIV sequencer.
//   state_t  : FSM state encoding (3-bit)
//   OP_MULT / OP_DIV : values of the op input
package mult_div_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_ctrl.sv
// Multi-cycle signed MULT/DIV sequencer owning the HI/LO registers.
// Operands are latched as magnitudes; WIDTH iterations of shift-add (mult)
// or restoring division run on one shared adder/subtractor, and a final FIX
// cycle applies the sign correction before HI/LO are written.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low; clears all state
//   start, op  : request pulse and operation (0 = MULT, 1 = DIV), IDLE only
//   a_in, b_in : signed operands (multiplicand/dividend, multiplier/divisor)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when HI/LO hold a new result
//   div_zero   : one-cycle pulse for DIV by zero; HI/LO untouched
//   hi_out, lo_out : HI/LO register contents
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t             state, nextState;
    logic [CNT_W-1:0]   iterCnt;
    logic               opReg, signA, signB;
    // MULT: opnd = |multiplicand|, {accHi, accLo} = running product.
    // DIV : opnd = |divisor|, accHi = remainder, accLo = dividend/quotient.
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     accHi;
    logic [WIDTH-1:0]   accLo;

    logic [WIDTH-1:0]   absA, absB;
    logic               lastIter;
    logic [WIDTH:0]     divShift, addA, addB, addRes, mulSum;
    logic               trialOk;
    logic [2*WIDTH-1:0] prodMag, prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;

    // Most negative input maps to itself, which as an unsigned magnitude is
    // exactly 2^(WIDTH-1), so the overflow case needs no special handling.
    assign absA     = a_in[WIDTH-1] ? -a_in : a_in;
    assign absB     = b_in[WIDTH-1] ? -b_in : b_in;
    assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

    // Single shared adder: add for MULT, trial subtract for DIV.
    assign divShift = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
    assign addA     = (opReg == OP_DIV) ? divShift : accHi;
    assign addB     = {1'b0, opnd};
    assign addRes   = (opReg == OP_DIV) ? (addA - addB) : (addA + addB);
    assign mulSum   = accLo[0] ? addRes : accHi;
    // Both operands of the trial subtract are < 2^WIDTH, so bit WIDTH is the borrow.
    assign trialOk  = ~addRes[WIDTH];

    assign prodMag  = {accHi[WIDTH-1:0], accLo};
    assign prodFix  = (signA ^ signB) ? -prodMag : prodMag;
    assign quoFix   = (signA ^ signB) ? -accLo : accLo;
    assign remFix   = signA ? -accHi[WIDTH-1:0] : accHi[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        div_zero  = (state == S_ERR);
        case (state)
            S_IDLE: if (start) nextState = (op == OP_DIV && b_in == '0) ? S_ERR : S_RUN;
            S_RUN:  if (lastIter) nextState = S_FIX;
            S_FIX:  nextState = S_DONE;
            S_DONE: nextState = S_IDLE;
            S_ERR:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iterCnt <= '0;
            opReg   <= OP_MULT;
            signA   <= 1'b0;
            signB   <= 1'b0;
            opnd    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    opReg   <= op;
                    signA   <= a_in[WIDTH-1];
                    signB   <= b_in[WIDTH-1];
                    iterCnt <= '0;
                    accHi   <= '0;
                    opnd    <= (op == OP_DIV) ? absB : absA;
                    accLo   <= (op == OP_DIV) ? absA : absB;
                end
                S_RUN: begin
                    iterCnt <= iterCnt + CNT_W'(1);
                    if (opReg == OP_DIV) begin
                        accHi <= trialOk ? addRes : divShift;
                        accLo <= {accLo[WIDTH-2:0], trialOk};
                    end else begin
                        accHi <= {1'b0, mulSum[WIDTH:1]};
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (opReg == OP_DIV) begin
                        hi_out <= remFix;
                        lo_out <= quoFix;
                    end else begin
                        hi_out <= prodFix[2*WIDTH-1:WIDTH];
                        lo_out <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
module tb_mult_div_ctrl;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [W-1:0]  aIn, bIn;
    logic          busy, done, divZero;
    logic [W-1:0]  hiOut, loOut;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    mult_div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(aIn), .b_in(bIn), .busy(busy), .done(done),
        .div_zero(divZero), .hi_out(hiOut), .lo_out(loOut)
    );

    always #5 clk = ~clk;

    // Reference: signed arithmetic on 64-bit integers. Division truncates
    // toward zero and the remainder takes the dividend's sign.
    function automatic void model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        longint la, lb, p, q, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (o == 1'b0) begin
            p  = la * lb;
            eh = p[63:32];
            el = p[31:0];
        end else begin
            q  = la / lb;
            r  = la % lb;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issues one request and waits for done or div_zero. lat counts edges
    // after the start edge (-1 on timeout); one further cycle is then sampled.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic gotZero,
                         output logic busyAfter, output logic doneAfter);
        @(negedge clk);
        start = 1'b1; op = o; aIn = a; bIn = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; gotZero = 1'b0;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (done || divZero) begin
                lat = k;
                gotZero = divZero;
            end
        end
        @(posedge clk); #1;
        busyAfter = busy;
        doneAfter = done | divZero;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; aIn = '0; bIn = '0;
        #12;
        vectors++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", divZero); end
        vectors++; if (hiOut !== '0)     begin errors++; $display("FAIL reset_hi got %h want 0", hiOut); end
        vectors++; if (loOut !== '0)     begin errors++; $display("FAIL reset_lo got %h want 0", loOut); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic run_checked(input string name, input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat; logic z, bA, dA;
        logic [W-1:0] eh, el;
        do_op(o, a, b, lat, z, bA, dA);
        if (o == 1'b1 && b == '0) begin
            vectors++; if (lat !== 0 || z !== 1'b1) begin errors++; $display("FAIL %s divzero_lat got %0d/%b want 0/1", name, lat, z); end
        end else begin
            model(o, a, b, eh, el);
            expHi = eh; expLo = el;
            vectors++; if (lat !== LAT || z !== 1'b0) begin errors++; $display("FAIL %s latency got %0d/%b want %0d/0", name, lat, z, LAT); end
        end
        vectors++; if (hiOut !== expHi) begin errors++; $display("FAIL %s hi got %h want %h", name, hiOut, expHi); end
        vectors++; if (loOut !== expLo) begin errors++; $display("FAIL %s lo got %h want %h", name, loOut, expLo); end
        vectors++; if (bA !== 1'b0 || dA !== 1'b0) begin errors++; $display("FAIL %s after got busy=%b pulse=%b want 0/0", name, bA, dA); end
    endtask

    task automatic test_mult_directed();
        run_checked("mult_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD);
        vectors++; if (hiOut !== 32'hFFFF_FFFF || loOut !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_7x-3_const got %h_%h want ffffffff_ffffffeb", hiOut, loOut); end
        run_checked("mult_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        vectors++; if (hiOut !== 32'h3FFF_FFFF || loOut !== 32'h0000_0001) begin
            errors++; $display("FAIL mult_max_const got %h_%h want 3fffffff_00000001", hiOut, loOut); end
        run_checked("mult_minmin", 1'b0, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_directed();
        run_checked("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        vectors++; if (hiOut !== 32'hFFFF_FFFF || loOut !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_-7/2_const got %h_%h want ffffffff_fffffffd", hiOut, loOut); end
        run_checked("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        vectors++; if (hiOut !== 32'h0 || loOut !== 32'h8000_0000) begin
            errors++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", hiOut, loOut); end
        run_checked("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        logic [W-1:0] h0, l0;
        h0 = expHi; l0 = expLo;
        run_checked("div_5/0", 1'b1, 32'd5, 32'd0);
        vectors++; if (hiOut !== h0 || loOut !== l0) begin
            errors++; $display("FAIL div0_hold got %h_%h want %h_%h", hiOut, loOut, h0, l0); end
    endtask

    task automatic test_ignore_start();
        int lat;
        logic [W-1:0] eh, el;
        @(negedge clk);
        start = 1'b1; op = 1'b0; aIn = 32'd1234; bIn = 32'hFFFF_FF00;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 5) begin start = 1'b1; op = 1'b1; aIn = 32'd99; bIn = 32'd0; end
            if (k == 6) start = 1'b0;
            if (done || divZero) lat = divZero ? 1000 : k;
        end
        model(1'b0, 32'd1234, 32'hFFFF_FF00, eh, el);
        expHi = eh; expLo = el;
        vectors++; if (lat !== LAT) begin errors++; $display("FAIL ignore_start latency got %0d want %0d", lat, LAT); end
        vectors++; if (hiOut !== eh || loOut !== el) begin
            errors++; $display("FAIL ignore_start result got %h_%h want %h_%h", hiOut, loOut, eh, el); end
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; aIn = 32'd55; bIn = 32'd66;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        expHi = '0; expLo = '0;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy); end
        vectors++; if (hiOut !== '0 || loOut !== '0) begin
            errors++; $display("FAIL reset_mid hilo got %h_%h want 0_0", hiOut, loOut); end
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid activity got %0d want 0", pulses); end
        run_checked("mult_after_reset", 1'b0, 32'hFFFF_FFF0, 32'd3);
    endtask

    task automatic test_random();
        logic o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) b = '0;
            run_checked($sformatf("rand%0d", i), o, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
